// File: rtl/iommu_hpm_evt_sched_pkg.sv
// ---------------------------------------------------------------------------
// rv_iommu : shared IOMMU definitions used by the HPM event scheduler.
//   hpm_evt_t       - event record carried from a requester to the HPM
//   hpm_evt_id_e    - HPM event identifiers the scheduler forwards
//   HPM_DROP_CNT_W  - width of the per-requester drop counters
//   hpm_evt_decode  - eventid -> one-hot pulse vector
//                     bit0 tr_request, bit1 iotlb_miss, bit2 ddt_walk,
//                     bit3 pdt_walk, bit4 s1_ptw, bit5 s2_ptw
//                     (all zero for an id the HPM does not count)
// ---------------------------------------------------------------------------
package rv_iommu;

   localparam int HPM_DROP_CNT_W = 16;

   typedef enum logic [4:0] {
      HPM_EVT_UT_REQ     = 5'd1,
      HPM_EVT_IOTLB_MISS = 5'd4,
      HPM_EVT_DDTW       = 5'd5,
      HPM_EVT_PDTW       = 5'd6,
      HPM_EVT_S1_PTW     = 5'd7,
      HPM_EVT_S2_PTW     = 5'd8
   } hpm_evt_id_e;

   // eventid is plain logic: requesters may present ids outside the enum.
   typedef struct packed {
      logic [4:0]  eventid;
      logic [23:0] did;
      logic [19:0] pid;
      logic [19:0] pscid;
      logic [15:0] gscid;
      logic        pid_v;
   } hpm_evt_t;

   function automatic logic [5:0] hpm_evt_decode(input logic [4:0] id);
      logic [5:0] dec;
      dec = '0;
      case (id)
         HPM_EVT_UT_REQ:     dec = 6'b000001;
         HPM_EVT_IOTLB_MISS: dec = 6'b000010;
         HPM_EVT_DDTW:       dec = 6'b000100;
         HPM_EVT_PDTW:       dec = 6'b001000;
         HPM_EVT_S1_PTW:     dec = 6'b010000;
         HPM_EVT_S2_PTW:     dec = 6'b100000;
         default:            dec = 6'b000000;
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/iommu_hpm_evt_sched_if.sv
// ---------------------------------------------------------------------------
// iommu_hpm_evt_sched_if : requester-side event bus of the HPM scheduler.
//   evt_valid_i[N_REQ]  one-cycle event pulse per requester (no back-pressure)
//   evt_i[N_REQ]        event record per requester
//   master : requesters (drive), slave : scheduler (sample)
// ---------------------------------------------------------------------------
interface iommu_hpm_evt_sched_if
   import rv_iommu::*;
#(
   parameter int N_REQ = 2
);
   logic     [N_REQ-1:0] evt_valid_i;
   hpm_evt_t [N_REQ-1:0] evt_i;

   modport master (output evt_valid_i, output evt_i);
   modport slave  (input  evt_valid_i, input  evt_i);
endinterface

// File: rtl/iommu_hpm_evt_fifo.sv
// ---------------------------------------------------------------------------
// iommu_hpm_evt_fifo : one requester's event queue.
//   clk_i, rst_i  clock, asynchronous active-high reset (pointers only)
//   flush_i       empties the queue at the next edge, any push is ignored
//   push_i/pop_i  write accepted if not full, or if popped in the same cycle
//   full_o/empty_o occupancy flags, head_o oldest entry (valid when !empty_o)
// Pointers carry one wrap bit above the index so full and empty differ.
// ---------------------------------------------------------------------------
module iommu_hpm_evt_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
   input  logic push_i,
   input  logic pop_i,
   input  T     data_i,
   output logic full_o,
   output logic empty_o,
   output T     head_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   T            r_mem [DEPTH];
   logic        w_wr;

   assign w_wr    = push_i && (!full_o || pop_i) && !flush_i;
   assign empty_o = (r_wptr == r_rptr);
   assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign head_o  = r_mem[r_rptr[AW-1:0]];

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (flush_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr)              r_wptr <= r_wptr + 1'b1;
         if (pop_i && !empty_o) r_rptr <= r_rptr + 1'b1;
      end
   end

   // NOTE: entry storage has no reset; the pointers alone decide what is valid.
   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= data_i;
   end
endmodule

// File: rtl/iommu_hpm_evt_sched.sv
// ---------------------------------------------------------------------------
// iommu_hpm_evt_sched : queues HPM event pulses per requester and drains them
// round-robin, one per cycle, onto the single HPM event/ID port.
//   clk_i, rst_i         clock, asynchronous active-high reset
//   evt_if (slave)       per-requester evt_valid_i / evt_i
//   flush_i              discard every queued event and the presented one
//   ovf_clr_i[N_REQ]     clear overflow flag (and drop counter)
//   *_o pulses / IDs     registered one-cycle event presented to the HPM
//   ovf_o[N_REQ]         sticky drop flag per requester
//   drop_cnt_o[N_REQ]    saturating drop count (IOMMU_HPM_DROP_CNT_EN only,
//                        otherwise tied to zero)
//   busy_o               any queue occupied or an event presented
// ---------------------------------------------------------------------------
module iommu_hpm_evt_sched
   import rv_iommu::*;
#(
   parameter int N_REQ      = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   iommu_hpm_evt_sched_if.slave                 evt_if,
   input  logic                                 flush_i,
   input  logic [N_REQ-1:0]                     ovf_clr_i,
   output logic                                 tr_request_o,
   output logic                                 iotlb_miss_o,
   output logic                                 ddt_walk_o,
   output logic                                 pdt_walk_o,
   output logic                                 s1_ptw_o,
   output logic                                 s2_ptw_o,
   output logic [23:0]                          did_o,
   output logic [19:0]                          pid_o,
   output logic [19:0]                          pscid_o,
   output logic [15:0]                          gscid_o,
   output logic                                 pid_v_o,
   output logic [N_REQ-1:0]                     ovf_o,
   output logic [N_REQ-1:0][HPM_DROP_CNT_W-1:0] drop_cnt_o,
   output logic                                 busy_o
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] w_push, w_pop, w_full, w_empty, w_drop;
   hpm_evt_t         w_head [N_REQ];
   hpm_evt_t         w_sel;
   logic             w_gnt_vld, w_take;
   logic [IDX_W-1:0] w_gnt_idx, w_cand;

   logic [IDX_W-1:0] r_last;
   logic             r_out_vld;
   logic [5:0]       r_pulse;
   logic [23:0]      r_did;
   logic [19:0]      r_pid, r_pscid;
   logic [15:0]      r_gscid;
   logic             r_pid_v;
   logic [N_REQ-1:0] r_ovf;

   for (genvar g = 0; g < N_REQ; g++) begin : g_req
      // Unknown event ids never enter a queue, so they can never be drops.
      assign w_push[g] = evt_if.evt_valid_i[g] && !flush_i &&
                         (hpm_evt_decode(evt_if.evt_i[g].eventid) != 6'b0);
      assign w_pop[g]  = w_take && (w_gnt_idx == IDX_W'(g));
      assign w_drop[g] = w_push[g] && w_full[g] && !w_pop[g];

      iommu_hpm_evt_fifo #(
         .DEPTH (FIFO_DEPTH),
         .T     (hpm_evt_t)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i),
         .push_i  (w_push[g]),
         .pop_i   (w_pop[g]),
         .data_i  (evt_if.evt_i[g]),
         .full_o  (w_full[g]),
         .empty_o (w_empty[g]),
         .head_o  (w_head[g])
      );
   end

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      w_gnt_vld = 1'b0;
      w_gnt_idx = r_last;
      w_cand    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_cand = IDX_W'((int'(r_last) + i) % N_REQ);
         if (!w_gnt_vld && !w_empty[w_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   assign w_take = w_gnt_vld && !flush_i;
   assign w_sel  = w_take ? w_head[w_gnt_idx] : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last    <= IDX_W'(N_REQ - 1);
         r_out_vld <= 1'b0;
         r_pulse   <= '0;
         r_did     <= '0;
         r_pid     <= '0;
         r_pscid   <= '0;
         r_gscid   <= '0;
         r_pid_v   <= 1'b0;
      end else begin
         // w_sel is all-zero when nothing is taken, which clears the port.
         r_out_vld <= w_take;
         r_pulse   <= w_take ? hpm_evt_decode(w_sel.eventid) : 6'b0;
         r_did     <= w_sel.did;
         r_pid     <= w_sel.pid;
         r_pscid   <= w_sel.pscid;
         r_gscid   <= w_sel.gscid;
         r_pid_v   <= w_sel.pid_v;
         if (w_take) r_last <= w_gnt_idx;
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf <= '0;
      end else begin
         for (int r = 0; r < N_REQ; r++) begin
            if (w_drop[r])         r_ovf[r] <= 1'b1;
            else if (ovf_clr_i[r]) r_ovf[r] <= 1'b0;
         end
      end
   end

`ifdef IOMMU_HPM_DROP_CNT_EN
   logic [N_REQ-1:0][HPM_DROP_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else begin
         for (int r = 0; r < N_REQ; r++) begin
            if (w_drop[r]) begin
               if (ovf_clr_i[r])   r_cnt[r] <= HPM_DROP_CNT_W'(1);
               else if (!(&r_cnt[r])) r_cnt[r] <= r_cnt[r] + 1'b1;
            end else if (ovf_clr_i[r]) begin
               r_cnt[r] <= '0;
            end
         end
      end
   end

   assign drop_cnt_o = r_cnt;
`else
   assign drop_cnt_o = '0;
`endif

   assign tr_request_o = r_pulse[0];
   assign iotlb_miss_o = r_pulse[1];
   assign ddt_walk_o   = r_pulse[2];
   assign pdt_walk_o   = r_pulse[3];
   assign s1_ptw_o     = r_pulse[4];
   assign s2_ptw_o     = r_pulse[5];
   assign did_o        = r_did;
   assign pid_o        = r_pid;
   assign pscid_o      = r_pscid;
   assign gscid_o      = r_gscid;
   assign pid_v_o      = r_pid_v;
   assign ovf_o        = r_ovf;
   assign busy_o       = !(&w_empty) || r_out_vld;
endmodule

// File: tb/tb_iommu_hpm_evt_sched.sv
// ---------------------------------------------------------------------------
// tb_iommu_hpm_evt_sched : self-checking bench for iommu_hpm_evt_sched.
// A queue-based reference model predicts every output each cycle. A second
// instance with 8-deep queues shares the stimulus and is used for the
// lossless two-requester contention scenario.
// ---------------------------------------------------------------------------
module tb_iommu_hpm_evt_sched;
   import rv_iommu::*;

   localparam int N = 2;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           flush;
   logic [N-1:0]   clr;
   int             n_cmp = 0;
   int             n_bad = 0;

   always #5 clk = ~clk;

   iommu_hpm_evt_sched_if #(.N_REQ(N)) evt_if ();

   logic              tr, iotlb, ddt, pdt, s1, s2, pidv, busy;
   logic [23:0]       did;
   logic [19:0]       pid, pscid;
   logic [15:0]       gscid;
   logic [N-1:0]      ovf;
   logic [N-1:0][15:0] cnt;

   logic              tr8, iotlb8, ddt8, pdt8, s18, s28, pidv8, busy8;
   logic [23:0]       did8;
   logic [19:0]       pid8, pscid8;
   logic [15:0]       gscid8;
   logic [N-1:0]      ovf8;
   logic [N-1:0][15:0] cnt8;

   iommu_hpm_evt_sched #(.N_REQ(N), .FIFO_DEPTH(D)) dut (
      .clk_i(clk), .rst_i(rst), .evt_if(evt_if), .flush_i(flush), .ovf_clr_i(clr),
      .tr_request_o(tr), .iotlb_miss_o(iotlb), .ddt_walk_o(ddt), .pdt_walk_o(pdt),
      .s1_ptw_o(s1), .s2_ptw_o(s2), .did_o(did), .pid_o(pid), .pscid_o(pscid),
      .gscid_o(gscid), .pid_v_o(pidv), .ovf_o(ovf), .drop_cnt_o(cnt), .busy_o(busy));

   iommu_hpm_evt_sched #(.N_REQ(N), .FIFO_DEPTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .evt_if(evt_if), .flush_i(flush), .ovf_clr_i(clr),
      .tr_request_o(tr8), .iotlb_miss_o(iotlb8), .ddt_walk_o(ddt8), .pdt_walk_o(pdt8),
      .s1_ptw_o(s18), .s2_ptw_o(s28), .did_o(did8), .pid_o(pid8), .pscid_o(pscid8),
      .gscid_o(gscid8), .pid_v_o(pidv8), .ovf_o(ovf8), .drop_cnt_o(cnt8), .busy_o(busy8));

   wire [121:0] obs = {tr, iotlb, ddt, pdt, s1, s2, did, pid, pscid, gscid, pidv, ovf, cnt, busy};
   wire         any8 = tr8 | iotlb8 | ddt8 | pdt8 | s18 | s28;

   // ---------------- reference model ----------------
   hpm_evt_t m_q [N][$];
   int       m_last;
   bit       m_ovf [N];
   int       m_cnt [N];
   bit       m_ov;
   hpm_evt_t m_oe;

   function automatic logic [5:0] pulse_of(input logic [4:0] id);
      case (id)
         HPM_EVT_UT_REQ:     return 6'b100000;
         HPM_EVT_IOTLB_MISS: return 6'b010000;
         HPM_EVT_DDTW:       return 6'b001000;
         HPM_EVT_PDTW:       return 6'b000100;
         HPM_EVT_S1_PTW:     return 6'b000010;
         HPM_EVT_S2_PTW:     return 6'b000001;
         default:            return 6'b000000;
      endcase
   endfunction

   function automatic int m_grant();
      for (int i = 1; i <= N; i++) begin
         if (m_q[(m_last + i) % N].size() != 0) return (m_last + i) % N;
      end
      return -1;
   endfunction

   function automatic bit m_busy();
      bit b = m_ov;
      for (int r = 0; r < N; r++) if (m_q[r].size() != 0) b = 1;
      return b;
   endfunction

   function automatic logic [121:0] exp_bus();
      logic [5:0]         p = '0;
      hpm_evt_t           e = '0;
      logic [N-1:0]       o = '0;
      logic [N-1:0][15:0] c = '0;
      if (m_ov) begin
         p = pulse_of(m_oe.eventid);
         e = m_oe;
      end
      for (int r = 0; r < N; r++) begin
         o[r] = m_ovf[r];
`ifdef IOMMU_HPM_DROP_CNT_EN
         c[r] = 16'(m_cnt[r]);
`endif
      end
      return {p, e.did, e.pid, e.pscid, e.gscid, e.pid_v, o, c, m_busy()};
   endfunction

   task automatic model_reset();
      for (int r = 0; r < N; r++) begin
         m_q[r].delete();
         m_ovf[r] = 0;
         m_cnt[r] = 0;
      end
      m_last = N - 1;
      m_ov   = 0;
      m_oe   = '0;
   endtask

   // One rising edge: the arbiter pops from pre-edge occupancy, then pushes land.
   task automatic model_step();
      int g;
      bit drop;
      g = flush ? -1 : m_grant();
      if (flush) for (int r = 0; r < N; r++) m_q[r].delete();
      if (g >= 0) begin
         m_oe   = m_q[g].pop_front();
         m_ov   = 1;
         m_last = g;
      end else begin
         m_oe = '0;
         m_ov = 0;
      end
      for (int r = 0; r < N; r++) begin
         drop = 0;
         if (!flush && evt_if.evt_valid_i[r] && pulse_of(evt_if.evt_i[r].eventid) != 0) begin
            if (m_q[r].size() < D) m_q[r].push_back(evt_if.evt_i[r]);
            else drop = 1;
         end
         if (drop) begin
            m_ovf[r] = 1;
            m_cnt[r] = clr[r] ? 1 : ((m_cnt[r] < 65535) ? m_cnt[r] + 1 : 65535);
         end else if (clr[r]) begin
            m_ovf[r] = 0;
            m_cnt[r] = 0;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic hpm_evt_t rand_evt(input int bad_pct, input int tag);
      hpm_evt_t    e;
      logic [4:0]  ids [6] = '{HPM_EVT_UT_REQ, HPM_EVT_IOTLB_MISS, HPM_EVT_DDTW,
                               HPM_EVT_PDTW, HPM_EVT_S1_PTW, HPM_EVT_S2_PTW};
      e.eventid = ($urandom_range(0, 99) < bad_pct) ? 5'($urandom_range(0, 31))
                                                   : ids[$urandom_range(0, 5)];
      e.did     = 24'($urandom);
      e.pid     = 20'($urandom);
      e.pscid   = 20'($urandom);
      e.gscid   = 16'($urandom);
      e.pid_v   = 1'($urandom);
      if (tag >= 0) e.did[0] = 1'(tag);
      return e;
   endfunction

   task automatic set_idle();
      evt_if.evt_valid_i = '0;
      flush = 1'b0;
      clr   = '0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      set_idle();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && m_busy(); i++) step();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drain: busy_o=%b required 0", busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_idle();
      model_reset();
      @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== exp_bus()) begin
         n_bad++;
         $display("FAIL reset_state: got %h required %h", obs, exp_bus());
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (obs !== exp_bus()) begin
         n_bad++;
         $display("FAIL reset_idle: got %h required %h", obs, exp_bus());
      end
   endtask

   task automatic test_single();
      hpm_evt_t e = rand_evt(0, -1);
      e.eventid = HPM_EVT_IOTLB_MISS;
      e.did     = 24'h12345;
      evt_if.evt_i[0]       = e;
      evt_if.evt_valid_i[0] = 1'b1;
      step();
      set_idle();
      n_cmp++;
      if (iotlb !== 1'b0) begin
         n_bad++;
         $display("FAIL single_early: iotlb_miss_o=%b required 0", iotlb);
      end
      step();
      n_cmp++;
      if ({tr, iotlb, ddt, pdt, s1, s2} !== 6'b010000 || did !== 24'h12345) begin
         n_bad++;
         $display("FAIL single_out: pulses=%b did=%h required 010000 12345",
                  {tr, iotlb, ddt, pdt, s1, s2}, did);
      end
      n_cmp++;
      if (obs !== exp_bus()) begin
         n_bad++;
         $display("FAIL single_model: got %h required %h", obs, exp_bus());
      end
      step();
      n_cmp++;
      if (iotlb !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL single_end: iotlb_miss_o=%b busy_o=%b required 0 0", iotlb, busy);
      end
   endtask

   task automatic test_contention();
      int n8 = 0;
      apply_reset();
      for (int c = 0; c < 40; c++) begin
         if (c < 8) begin
            for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
            evt_if.evt_valid_i = '1;
         end else begin
            set_idle();
         end
         step();
         n_cmp++;
         if (obs !== exp_bus()) begin
            n_bad++;
            $display("FAIL contention_model c=%0d: got %h required %h", c, obs, exp_bus());
         end
         if (any8) begin
            n_cmp++;
            if (did8[0] !== 1'(n8 % 2)) begin
               n_bad++;
               $display("FAIL contention_order #%0d: requester %0d required %0d", n8, did8[0], n8 % 2);
            end
            n8++;
         end
         if (c >= 8 && !busy8 && !m_busy()) break;
      end
      n_cmp++;
      if (n8 != 16 || ovf8 !== 2'b00 || busy8 !== 1'b0) begin
         n_bad++;
         $display("FAIL contention_total: outputs=%0d ovf=%b busy=%b required 16 00 0", n8, ovf8, busy8);
      end
   endtask

   task automatic test_overflow();
      bit hit = 0;
      drain();
      for (int c = 0; c < 10; c++) begin
         for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
         evt_if.evt_valid_i = '1;
         step();
         n_cmp++;
         if (obs !== exp_bus()) begin
            n_bad++;
            $display("FAIL overflow_model c=%0d: got %h required %h", c, obs, exp_bus());
         end
      end
      n_cmp++;
`ifdef IOMMU_HPM_DROP_CNT_EN
      if (ovf[1] !== 1'b1 || cnt[1] !== 16'(m_cnt[1])) begin
`else
      if (ovf[1] !== 1'b1 || cnt[1] !== 16'h0) begin
`endif
         n_bad++;
         $display("FAIL overflow_flag: ovf=%b cnt=%0d required 1 %0d", ovf[1], cnt[1], m_cnt[1]);
      end
      // Clear requester 1 in a cycle where it is full and not granted.
      for (int c = 0; c < 6 && !hit; c++) begin
         for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
         evt_if.evt_valid_i = '1;
         if (m_q[1].size() == D && m_grant() != 1) begin
            clr[1] = 1'b1;
            hit    = 1;
         end
         step();
         clr = '0;
         if (hit) begin
            n_cmp++;
`ifdef IOMMU_HPM_DROP_CNT_EN
            if (ovf[1] !== 1'b1 || cnt[1] !== 16'd1) begin
`else
            if (ovf[1] !== 1'b1 || cnt[1] !== 16'd0) begin
`endif
               n_bad++;
               $display("FAIL overflow_clr_vs_drop: ovf=%b cnt=%0d", ovf[1], cnt[1]);
            end
         end
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL overflow_clr_vs_drop: no full cycle found (got 0 required 1)");
      end
      set_idle();
      clr[1] = 1'b1;
      step();
      clr = '0;
      n_cmp++;
      if (ovf[1] !== 1'b0 || obs !== exp_bus()) begin
         n_bad++;
         $display("FAIL overflow_clear: got %h required %h", obs, exp_bus());
      end
      drain();
   endtask

   task automatic test_flush();
      logic [N-1:0][15:0] saved;
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
         evt_if.evt_valid_i = '1;
         step();
      end
      saved = cnt;
      for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
      flush = 1'b1;
      step();
      set_idle();
      n_cmp++;
      if (busy !== 1'b0 || {tr, iotlb, ddt, pdt, s1, s2} !== 6'b0) begin
         n_bad++;
         $display("FAIL flush_now: busy=%b pulses=%b required 0 000000", busy, {tr, iotlb, ddt, pdt, s1, s2});
      end
      for (int c = 0; c < 4; c++) begin
         step();
         n_cmp++;
         if ({tr, iotlb, ddt, pdt, s1, s2} !== 6'b0 || cnt !== saved || obs !== exp_bus()) begin
            n_bad++;
            $display("FAIL flush_after c=%0d: got %h required %h", c, obs, exp_bus());
         end
      end
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
         evt_if.evt_valid_i = '1;
         step();
      end
      #3;
      rst = 1'b1;
      set_idle();
      model_reset();
      #1;
      n_cmp++;
      if (obs !== exp_bus()) begin
         n_bad++;
         $display("FAIL async_reset: got %h required %h", obs, exp_bus());
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(0, r);
      evt_if.evt_valid_i = '1;
      step();
      set_idle();
      step();
      n_cmp++;
      if ({tr, iotlb, ddt, pdt, s1, s2} == 6'b0 || did[0] !== 1'b0 || obs !== exp_bus()) begin
         n_bad++;
         $display("FAIL async_first_grant: got %h required %h", obs, exp_bus());
      end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int r = 0; r < N; r++) evt_if.evt_i[r] = rand_evt(25, -1);
         evt_if.evt_valid_i = N'($urandom);
         flush = ($urandom_range(0, 19) == 0);
         for (int r = 0; r < N; r++) clr[r] = ($urandom_range(0, 9) == 0);
         step();
         n_cmp++;
         if (obs !== exp_bus()) begin
            n_bad++;
            $display("FAIL random c=%0d: got %h required %h", c, obs, exp_bus());
         end
      end
      set_idle();
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_overflow();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
